// File: rtl/csr_access_unit.sv
// csr_access_unit: initiator side of the CSR access interface.
// Executes one Zicsr instruction (CSRRW/S/C and the immediate forms) as a
// read-modify-write against an external CSR file. The file's read port is
// combinational and its write port is written on the clock edge. The unit
// returns the old CSR value for rd, or flags an illegal instruction.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req_*, o_req_ready    request from the execute stage (valid/ready)
//   o_csr_read_address      CSR file read port address
//   i_csr_read_data         CSR file read data (combinational)
//   o_csr_write_*           CSR file write port (one-cycle strobe)
//   o_rsp_*, i_rsp_ready    response to writeback (valid/ready)
module csr_access_unit #(
  parameter bit CHECK_READ_ONLY = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [2:0]  i_req_funct3,
  input  logic [11:0] i_req_csr_addr,
  input  logic [4:0]  i_req_rs1_index,
  input  logic [31:0] i_req_rs1_value,
  input  logic [4:0]  i_req_rd_index,
  output logic [11:0] o_csr_read_address,
  input  logic [31:0] i_csr_read_data,
  output logic [11:0] o_csr_write_address,
  output logic [31:0] o_csr_write_data,
  output logic        o_csr_write_enable,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [4:0]  o_rsp_rd_index,
  output logic [31:0] o_rsp_rd_value,
  output logic        o_rsp_rd_write,
  output logic        o_rsp_illegal
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [2:0]  r_funct3;
  logic [11:0] r_addr;
  logic [4:0]  r_rs1_index;
  logic [31:0] r_rs1_value;
  logic [4:0]  r_rd_index;
  logic [31:0] r_old;
  logic [31:0] r_wdata;
  logic        r_illegal;

  logic [31:0] w_src;
  logic [31:0] w_new;
  logic        w_bad_funct3;
  logic        w_want_write;
  logic        w_read_only;
  logic        w_illegal;
  logic        w_accept;

  assign w_accept = i_req_valid && (r_state == StIdle);

  // Decode from latched fields; only meaningful while in StRead.
  assign w_src        = r_funct3[2] ? {27'b0, r_rs1_index} : r_rs1_value;
  assign w_bad_funct3 = (r_funct3[1:0] == 2'b00);
  // Set/clear forms with a zero source are pure reads and never write.
  assign w_want_write = (r_funct3[1:0] == 2'b01) || (r_rs1_index != 5'd0);
  assign w_read_only  = CHECK_READ_ONLY && (r_addr[11:10] == 2'b11);
  assign w_illegal    = w_bad_funct3 || (w_want_write && w_read_only);

  always_comb begin
    w_new = w_src;
    unique case (r_funct3[1:0])
      2'b01:   w_new = w_src;
      2'b10:   w_new = i_csr_read_data | w_src;
      2'b11:   w_new = i_csr_read_data & ~w_src;
      default: w_new = w_src;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StRead;
      StRead:  w_state_next = (w_want_write && !w_illegal) ? StWrite : StResp;
      StWrite: w_state_next = StResp;
      StResp:  if (i_rsp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_funct3    <= 3'd0;
      r_addr      <= 12'd0;
      r_rs1_index <= 5'd0;
      r_rs1_value <= 32'd0;
      r_rd_index  <= 5'd0;
      r_old       <= 32'd0;
      r_wdata     <= 32'd0;
      r_illegal   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_funct3    <= i_req_funct3;
        r_addr      <= i_req_csr_addr;
        r_rs1_index <= i_req_rs1_index;
        r_rs1_value <= i_req_rs1_value;
        r_rd_index  <= i_req_rd_index;
      end
      if (r_state == StRead) begin
        r_old     <= i_csr_read_data;
        r_illegal <= w_illegal;
        // Write data only changes when a write is actually going to happen.
        if (w_want_write && !w_illegal) begin
          r_wdata <= w_new;
        end
      end
    end
  end

  always_comb begin
    o_req_ready         = (r_state == StIdle);
    o_csr_read_address  = r_addr;
    o_csr_write_address = r_addr;
    o_csr_write_data    = r_wdata;
    o_csr_write_enable  = (r_state == StWrite);
    o_rsp_valid         = 1'b0;
    o_rsp_rd_index      = 5'd0;
    o_rsp_rd_value      = 32'd0;
    o_rsp_rd_write      = 1'b0;
    o_rsp_illegal       = 1'b0;
    if (r_state == StResp) begin
      o_rsp_valid    = 1'b1;
      o_rsp_rd_index = r_rd_index;
      o_rsp_rd_value = r_old;
      o_rsp_rd_write = !r_illegal && (r_rd_index != 5'd0);
      o_rsp_illegal  = r_illegal;
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed self-checking bench for csr_access_unit with a behavioural CSR file.
module tb_csr_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr_addr;
  logic [4:0]  req_rs1_index;
  logic [31:0] req_rs1_value;
  logic [4:0]  req_rd_index;
  logic [11:0] csr_read_address;
  logic [31:0] csr_read_data;
  logic [11:0] csr_write_address;
  logic [31:0] csr_write_data;
  logic        csr_write_enable;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_rd_index;
  logic [31:0] rsp_rd_value;
  logic        rsp_rd_write;
  logic        rsp_illegal;

  logic [31:0] mem [4096];

  int unsigned n_checks;
  int unsigned n_fails;

  // Observations from the last transaction.
  int          we_cycle;
  int          we_count;
  logic [31:0] we_data;
  logic [11:0] we_addr;
  int          rsp_cycle;

  csr_access_unit #(
    .CHECK_READ_ONLY(1'b1)
  ) u_dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_req_valid        (req_valid),
    .o_req_ready        (req_ready),
    .i_req_funct3       (req_funct3),
    .i_req_csr_addr     (req_csr_addr),
    .i_req_rs1_index    (req_rs1_index),
    .i_req_rs1_value    (req_rs1_value),
    .i_req_rd_index     (req_rd_index),
    .o_csr_read_address (csr_read_address),
    .i_csr_read_data    (csr_read_data),
    .o_csr_write_address(csr_write_address),
    .o_csr_write_data   (csr_write_data),
    .o_csr_write_enable (csr_write_enable),
    .o_rsp_valid        (rsp_valid),
    .i_rsp_ready        (rsp_ready),
    .o_rsp_rd_index     (rsp_rd_index),
    .o_rsp_rd_value     (rsp_rd_value),
    .o_rsp_rd_write     (rsp_rd_write),
    .o_rsp_illegal      (rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign csr_read_data = mem[csr_read_address];

  always @(posedge clk) begin
    if (csr_write_enable) mem[csr_write_address] <= csr_write_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and observe until the response appears (bounded).
  // Cycle k counts negedges after the accepting posedge.
  task automatic do_req(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1i,
                        input logic [31:0] rs1v, input logic [4:0] rd);
    @(negedge clk);
    req_valid     = 1'b1;
    req_funct3    = f3;
    req_csr_addr  = addr;
    req_rs1_index = rs1i;
    req_rs1_value = rs1v;
    req_rd_index  = rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    we_cycle  = 0;
    we_count  = 0;
    rsp_cycle = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (csr_write_enable) begin
        we_cycle = k;
        we_count++;
        we_data  = csr_write_data;
        we_addr  = csr_write_address;
      end
      if (rsp_valid) begin
        rsp_cycle = k;
        break;
      end
    end
    check("rsp_timeout", 32'(rsp_cycle != 0), 32'd1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] h_value;
    n_checks      = 0;
    n_fails       = 0;
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    rsp_ready     = 1'b0;
    req_funct3    = 3'd0;
    req_csr_addr  = 12'd0;
    req_rs1_index = 5'd0;
    req_rs1_value = 32'd0;
    req_rd_index  = 5'd0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    mem[12'h300] = 32'h0000_0088;
    mem[12'hC00] = 32'h0000_1234;

    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_we", 32'(csr_write_enable), 32'd0);
    check("rst_raddr", 32'(csr_read_address), 32'd0);
    check("rst_waddr", 32'(csr_write_address), 32'd0);
    check("rst_wdata", csr_write_data, 32'd0);
    check("rst_rsp_fields", {rsp_rd_value[26:0], rsp_rd_index}, 32'd0);
    check("rst_rsp_flags", 32'({rsp_rd_write, rsp_illegal}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // CSRRW 0x340 <- 0xDEADBEEF, rd=5
    do_req(3'b001, 12'h340, 5'd1, 32'hDEAD_BEEF, 5'd5);
    check("rw_we_cycle", we_cycle, 2);
    check("rw_we_data", we_data, 32'hDEAD_BEEF);
    check("rw_we_addr", 32'(we_addr), 32'h340);
    check("rw_rsp_cycle", rsp_cycle, 3);
    check("rw_rd_value", rsp_rd_value, 32'h0);
    check("rw_rd_index", 32'(rsp_rd_index), 32'd5);
    check("rw_rd_write", 32'(rsp_rd_write), 32'd1);
    check("rw_illegal", 32'(rsp_illegal), 32'd0);
    handshake();
    check("rw_mem", mem[12'h340], 32'hDEAD_BEEF);

    // CSRRS x0 read-back
    do_req(3'b010, 12'h340, 5'd0, 32'hFFFF_FFFF, 5'd1);
    check("rb_we_count", we_count, 0);
    check("rb_rsp_cycle", rsp_cycle, 2);
    check("rb_rd_value", rsp_rd_value, 32'hDEAD_BEEF);
    handshake();

    // CSRRS rs1=x0 at 0x300, rd=3
    do_req(3'b010, 12'h300, 5'd0, 32'h0000_00FF, 5'd3);
    check("rs0_we_count", we_count, 0);
    check("rs0_rsp_cycle", rsp_cycle, 2);
    check("rs0_rd_value", rsp_rd_value, 32'h88);
    check("rs0_rd_write", 32'(rsp_rd_write), 32'd1);
    handshake();

    // CSRRCI uimm=3 at 0x340 holding 0xF, rd=0
    mem[12'h340] = 32'h0000_000F;
    do_req(3'b111, 12'h340, 5'd3, 32'hFFFF_FFFF, 5'd0);
    check("rci_we_data", we_data, 32'h0000_000C);
    check("rci_we_count", we_count, 1);
    check("rci_rd_value", rsp_rd_value, 32'h0000_000F);
    check("rci_rd_write", 32'(rsp_rd_write), 32'd0);
    handshake();
    check("rci_mem", mem[12'h340], 32'h0000_000C);

    // CSRRSI uimm=0x10 at 0x340 (0xC -> 0x1C)
    do_req(3'b110, 12'h340, 5'd16, 32'h0, 5'd7);
    check("rsi_we_data", we_data, 32'h0000_001C);
    check("rsi_rd_value", rsp_rd_value, 32'h0000_000C);
    handshake();

    // CSRRW to read-only 0xC00
    do_req(3'b001, 12'hC00, 5'd1, 32'h5555_5555, 5'd2);
    check("ro_illegal", 32'(rsp_illegal), 32'd1);
    check("ro_we_count", we_count, 0);
    check("ro_rd_write", 32'(rsp_rd_write), 32'd0);
    check("ro_rd_value", rsp_rd_value, 32'h1234);
    check("ro_rsp_cycle", rsp_cycle, 2);
    handshake();
    check("ro_mem", mem[12'hC00], 32'h1234);

    // CSRRS x0 at 0xC00 is a legal read
    do_req(3'b010, 12'hC00, 5'd0, 32'h0, 5'd2);
    check("ro_rd_illegal", 32'(rsp_illegal), 32'd0);
    check("ro_rd_val", rsp_rd_value, 32'h1234);
    check("ro_rd_wr", 32'(rsp_rd_write), 32'd1);
    handshake();

    // funct3=100 is illegal
    do_req(3'b100, 12'h340, 5'd1, 32'h1, 5'd4);
    check("f100_illegal", 32'(rsp_illegal), 32'd1);
    check("f100_we_count", we_count, 0);
    check("f100_rd_write", 32'(rsp_rd_write), 32'd0);
    handshake();

    // Stall in RESP with req_valid asserted; must be ignored
    mem[12'h305] = 32'hA5A5_0001;
    do_req(3'b010, 12'h305, 5'd0, 32'h0, 5'd9);
    h_value       = rsp_rd_value;
    check("stall_first", h_value, 32'hA5A5_0001);
    req_valid     = 1'b1;
    req_funct3    = 3'b001;
    req_csr_addr  = 12'h305;
    req_rs1_index = 5'd1;
    req_rs1_value = 32'h0BAD_0BAD;
    req_rd_index  = 5'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_value", rsp_rd_value, 32'hA5A5_0001);
      check("stall_index", 32'(rsp_rd_index), 32'd9);
      check("stall_ready", 32'(req_ready), 32'd0);
      check("stall_we", 32'(csr_write_enable), 32'd0);
    end
    req_valid = 1'b0;
    handshake();
    check("stall_mem", mem[12'h305], 32'hA5A5_0001);

    // Reset during the WRITE cycle aborts the write
    mem[12'h340] = 32'h0000_000C;
    @(negedge clk);
    req_valid     = 1'b1;
    req_funct3    = 3'b001;
    req_csr_addr  = 12'h340;
    req_rs1_index = 5'd1;
    req_rs1_value = 32'h0000_0055;
    req_rd_index  = 5'd6;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_we_before", 32'(csr_write_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_we_after", 32'(csr_write_enable), 32'd0);
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    check("mid_mem", mem[12'h340], 32'h0000_000C);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rel_ready", 32'(req_ready), 32'd1);
      check("rel_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    check("rel_mem", mem[12'h340], 32'h0000_000C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
